// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types for the pipelined
// immediate generator between decode and execute.
package imm_gen_pkg;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U,
    IMM_Z,
    IMM_SH,
    IMM_ILL
  } imm_src_e;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } pipe_state_e;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle carrying
// instruction/select/tag in and immediate/tag out.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic [2:0]             in_imm_src;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_imm;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic                   out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src,
    output in_tag, out_ready,
    input  in_ready, out_valid, out_imm,
    input  out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src,
    input  in_tag, out_ready,
    output in_ready, out_valid, out_imm,
    output out_tag, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32/RV64 immediate
// extraction, extended straight to XLEN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [2:0]             imm_src,
  output logic [XLEN-1:0]        imm,
  output logic                   illegal
);
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic s;
  logic unused_opc;

  assign s          = instr[31];
  assign unused_opc = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (imm_src_e'(imm_src))
      IMM_I:
        imm = {{(XLEN-12){s}}, instr[31:20]};
      IMM_S:
        imm = {{(XLEN-12){s}}, instr[31:25],
               instr[11:7]};
      IMM_B:
        imm = {{(XLEN-12){s}}, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      IMM_J:
        imm = {{(XLEN-20){s}}, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      IMM_U:
        imm = {{(XLEN-31){s}}, instr[30:12],
               12'b0};
      IMM_Z:
        imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      IMM_SH:
        imm = XLEN'(instr[20 +: SHW]);
      IMM_ILL:
        illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with
// a 2-entry skid buffer behind a valid/ready handshake.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  pipe_state_e state_q, state_d;

  logic                 rdy_q;
  logic                 acc_in;
  logic                 acc_out;
  logic                 ld_out;
  logic                 ld_skid;
  logic                 pop_skid;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_ill;
  logic [XLEN-1:0]      o_imm_q;
  logic [XLEN-1:0]      s_imm_q;
  logic [TAG_WIDTH-1:0] o_tag_q;
  logic [TAG_WIDTH-1:0] s_tag_q;
  logic                 o_ill_q;
  logic                 s_ill_q;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm_src (bus.in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign acc_in  = bus.in_valid && rdy_q;
  assign acc_out = (state_q != EMPTY)
                && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    pop_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc_in) begin
          state_d = BUSY;
          ld_out  = 1'b1;
        end
      end
      BUSY: begin
        if (acc_in && acc_out) begin
          ld_out = 1'b1;
        end else if (acc_in) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (acc_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (acc_out) begin
          state_d  = BUSY;
          pop_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is its own flop so out_ready never
  // reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_imm_q <= '0;
      o_tag_q <= '0;
      o_ill_q <= 1'b0;
      s_imm_q <= '0;
      s_tag_q <= '0;
      s_ill_q <= 1'b0;
    end else begin
      if (ld_out) begin
        o_imm_q <= dec_imm;
        o_tag_q <= bus.in_tag;
        o_ill_q <= dec_ill;
      end else if (pop_skid) begin
        o_imm_q <= s_imm_q;
        o_tag_q <= s_tag_q;
        o_ill_q <= s_ill_q;
      end
      if (ld_skid) begin
        s_imm_q <= dec_imm;
        s_tag_q <= bus.in_tag;
        s_ill_q <= dec_ill;
      end
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_imm     = o_imm_q;
  assign bus.out_tag     = o_tag_q;
  assign bus.out_illegal = o_ill_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32 and XLEN=64 instances
// driven in lockstep, scoreboarded against a model.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct packed {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_src = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_WIDTH(8)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_WIDTH(8)) b64 ();

  assign b32.in_valid   = in_valid;
  assign b32.in_instr   = in_instr;
  assign b32.in_imm_src = in_imm_src;
  assign b32.in_tag     = in_tag;
  assign b32.out_ready  = out_ready;
  assign b64.in_valid   = in_valid;
  assign b64.in_instr   = in_instr;
  assign b64.in_imm_src = in_imm_src;
  assign b64.in_tag     = in_tag;
  assign b64.out_ready  = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(8)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64)
  );

  function automatic logic [63:0] model(
    input logic [31:0] i,
    input logic [2:0]  src,
    input bit          x64
  );
    logic [63:0] sx;
    logic [63:0] r;
    sx = {64{i[31]}};
    case (src)
      3'd0: r = {sx[51:0], i[31:20]};
      3'd1: r = {sx[51:0], i[31:25], i[11:7]};
      3'd2: r = {sx[50:0], i[31], i[7], i[30:25],
                 i[11:8], 1'b0};
      3'd3: r = {sx[42:0], i[31], i[19:12], i[20],
                 i[30:21], 1'b0};
      3'd4: r = {sx[31:0], i[31:12], 12'h000};
      3'd5: r = {59'd0, i[19:15]};
      3'd6: r = x64 ? {58'd0, i[25:20]}
                    : {59'd0, i[24:20]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Mid-cycle scoreboard: inputs only change just
  // after posedge, so this sees what the next edge
  // will transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (b32.out_valid && b32.out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL sb32_extra got tag=%0d want none",
                   b32.out_tag);
        end else begin
          e = q32.pop_front();
          if ({b32.out_imm, b32.out_tag, b32.out_illegal}
              !== {e.imm[31:0], e.tag, e.ill}) begin
            errors++;
            $display("FAIL sb32 got %h/%0d/%b want %h/%0d/%b",
                     b32.out_imm, b32.out_tag,
                     b32.out_illegal, e.imm[31:0],
                     e.tag, e.ill);
          end
        end
      end
      if (b64.out_valid && b64.out_ready) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL sb64_extra got tag=%0d want none",
                   b64.out_tag);
        end else begin
          e = q64.pop_front();
          if ({b64.out_imm, b64.out_tag, b64.out_illegal}
              !== {e.imm, e.tag, e.ill}) begin
            errors++;
            $display("FAIL sb64 got %h/%0d/%b want %h/%0d/%b",
                     b64.out_imm, b64.out_tag,
                     b64.out_illegal, e.imm,
                     e.tag, e.ill);
          end
        end
      end
      if (b32.in_valid && b32.in_ready)
        q32.push_back({model(in_instr, in_imm_src, 1'b0),
                       in_tag, in_imm_src == 3'b111});
      if (b64.in_valid && b64.in_ready)
        q64.push_back({model(in_instr, in_imm_src, 1'b1),
                       in_tag, in_imm_src == 3'b111});
    end
  end

  task automatic send(
    input logic [31:0] ins,
    input logic [2:0]  src,
    input logic [7:0]  tag
  );
    bit acc;
    acc        = 1'b0;
    in_valid   = 1'b1;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tag;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = b32.in_ready && b64.in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout tag=%0d got no accept want accept",
               tag);
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = (q32.size() == 0) && (q64.size() == 0)
        && !b32.out_valid && !b64.out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_imm,
         b32.out_tag, b32.out_illegal}
        !== {1'b0, 1'b1, 32'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset32 got v=%b r=%b imm=%h tag=%h want 0/1/0/0",
               b32.out_valid, b32.in_ready,
               b32.out_imm, b32.out_tag);
    end
    checks++;
    if ({b64.out_valid, b64.in_ready, b64.out_imm,
         b64.out_tag, b64.out_illegal}
        !== {1'b0, 1'b1, 64'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset64 got v=%b r=%b imm=%h tag=%h want 0/1/0/0",
               b64.out_valid, b64.in_ready,
               b64.out_imm, b64.out_tag);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_formats();
    logic [31:0] fi [9];
    logic [2:0]  fs [9];
    logic [31:0] e32 [9];
    logic [63:0] e64 [9];
    fi  = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
            32'h0010006F, 32'h123452B7, 32'h800002B7,
            32'h03F00013, 32'h000F8073, 32'h7FF00093};
    fs  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4,
            3'd6, 3'd5, 3'd0};
    e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
            32'h00000800, 32'h12345000, 32'h80000000,
            32'h0000001F, 32'h0000001F, 32'h000007FF};
    e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
            64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
            64'h0000000012345000, 64'hFFFFFFFF80000000,
            64'h000000000000003F, 64'h000000000000001F,
            64'h00000000000007FF};
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      send(fi[k], fs[k], 8'(8'h10 + k));
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_illegal}
          !== {1'b1, e32[k], 1'b0}) begin
        errors++;
        $display("FAIL fmt32_%0d got v=%b imm=%h ill=%b want 1/%h/0",
                 k, b32.out_valid, b32.out_imm,
                 b32.out_illegal, e32[k]);
      end
      checks++;
      if ({b64.out_valid, b64.out_imm, b64.out_illegal}
          !== {1'b1, e64[k], 1'b0}) begin
        errors++;
        $display("FAIL fmt64_%0d got v=%b imm=%h ill=%b want 1/%h/0",
                 k, b64.out_valid, b64.out_imm,
                 b64.out_illegal, e64[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 3'b111, 8'h77);
    checks++;
    if ({b32.out_imm, b32.out_illegal, b64.out_imm,
         b64.out_illegal} !== {32'd0, 1'b1, 64'd0, 1'b1})
    begin
      errors++;
      $display("FAIL illegal got %h/%b %h/%b want 0/1",
               b32.out_imm, b32.out_illegal,
               b64.out_imm, b64.out_illegal);
    end
    send(32'h00100093, 3'd0, 8'h78);
    checks++;
    if ({b32.out_imm, b32.out_illegal, b64.out_illegal}
        !== {32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_illegal got imm=%h ill=%b/%b want 1/0/0",
               b32.out_imm, b32.out_illegal,
               b64.out_illegal);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          ok;
    out_ready = 1'b0;
    send(32'hABC00093, 3'd0, 8'd1);
    checks++;
    if (b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy_ready got %b want 1",
               b32.in_ready);
    end
    send(32'h80000037, 3'd4, 8'd2);
    checks++;
    if ({b32.in_ready, b64.in_ready, b32.out_valid,
         b32.out_tag} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL bp_full got r=%b/%b v=%b tag=%0d want 0/0/1/1",
               b32.in_ready, b64.in_ready,
               b32.out_valid, b32.out_tag);
    end
    held       = b32.out_imm;
    in_valid   = 1'b1;
    in_instr   = 32'hFE20AE23;
    in_imm_src = 3'd1;
    in_tag     = 8'd3;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({b32.out_tag, b64.out_tag, b32.out_imm,
           b32.in_ready} !== {8'd1, 8'd1, held, 1'b0})
      begin
        errors++;
        $display("FAIL bp_hold%0d got tag=%0d imm=%h r=%b want 1/%h/0",
                 n, b32.out_tag, b32.out_imm,
                 b32.in_ready, held);
      end
    end
    out_ready = 1'b1;
    send(32'hFE20AE23, 3'd1, 8'd3);
    send(32'h0010006F, 3'd3, 8'd4);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain got left=%0d/%0d want 0/0",
               q32.size(), q64.size());
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    bit  ok;
    out_ready = 1'b1;
    t0 = $time;
    for (int k = 0; k < 11; k++) begin
      send(32'(k) << 20 | 32'h13, 3'd0, 8'(8'h40 + k));
      if (k > 0) begin
        checks++;
        if ({b32.in_ready, b32.out_valid,
             b32.out_tag} !== {1'b1, 1'b1, 8'(8'h40 + k)})
        begin
          errors++;
          $display("FAIL b2b_%0d got r=%b v=%b tag=%0d want 1/1/%0d",
                   k, b32.in_ready, b32.out_valid,
                   b32.out_tag, 8'h40 + k);
        end
      end
    end
    checks++;
    if (($time - t0) !== 110) begin
      errors++;
      $display("FAIL b2b_rate got %0t want 110",
               $time - t0);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain got left=%0d want 0",
               q32.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd0, 8'h51);
    send(32'h123452B7, 3'd4, 8'h52);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b64.out_valid,
         b64.in_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL async_rst got v=%b r=%b v=%b r=%b want 0/1/0/1",
               b32.out_valid, b32.in_ready,
               b64.out_valid, b64.in_ready);
    end
    q32.delete();
    q64.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00500093, 3'd0, 8'hA5);
    checks++;
    if ({b32.out_valid, b32.out_tag, b32.out_imm,
         b64.out_tag, b64.out_imm}
        !== {1'b1, 8'hA5, 32'd5, 8'hA5, 64'd5}) begin
      errors++;
      $display("FAIL post_rst got v=%b tag=%h imm=%h want 1/a5/5",
               b32.out_valid, b32.out_tag, b32.out_imm);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_rst_drain got left=%0d want 0",
               q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
